// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester index map and default bus widths.
package mem_arb_pkg;

  localparam int MEMARB_AW = 16;
  localparam int MEMARB_DW = 16;

  localparam int REQ_PUSH0 = 0;
  localparam int REQ_PUSH1 = 1;
  localparam int REQ_POP0  = 2;
  localparam int REQ_POP1  = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_ACK   = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Circular priority encoder: picks the first set request at or after ptr_i,
// wrapping modulo N. Purely combinational so other arbiters can reuse it.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the farthest offset back to the nearest so the closest hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      int pos;
      pos = (int'(ptr_i) + off) % N;
      if (req_i[pos[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising ring-buffer push/pop engines onto one
// single-port memory bus. Optional grant counters with MEMARB_STATS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = MEMARB_AW,
  parameter int DW   = MEMARB_DW,
  parameter int CW   = 16
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*AW-1:0]        req_addr,
  input  logic [NREQ*DW-1:0]        req_wdata,
  output logic [NREQ-1:0]           ack,
  output logic [DW-1:0]             rdata,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      busy,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  output logic                      mem_wr,
  output logic                      mem_rd,
  input  logic [DW-1:0]             mem_rdata,
  input  logic                      mem_rvalid,
  input  logic                      mem_wdone
`ifdef MEMARB_STATS_EN
  ,
  output logic [NREQ*CW-1:0]        gnt_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            sel_valid;
  logic [IW-1:0]   sel_idx;

  rr_select #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_select (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  // Requests are only sampled in IDLE; the access parameters are frozen at grant.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          gnt_d   = sel_idx;
          we_d    = req_we[sel_idx];
          addr_d  = req_addr[int'(sel_idx)*AW +: AW];
          wdata_d = req_wdata[int'(sel_idx)*DW +: DW];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (we_q) begin
          if (mem_wdone) begin
            state_d = ST_ACK;
          end
        end else if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ST_ACK) begin
      ack[gnt_q] = 1'b1;
    end
  end

  assign mem_wr    = (state_q == ST_ISSUE) &&  we_q;
  assign mem_rd    = (state_q == ST_ISSUE) && !we_q;
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign gnt_id    = gnt_q;

`ifdef MEMARB_STATS_EN
  logic [NREQ*CW-1:0] cnt_q;

  // One saturating counter per requester, bumped once per completed access.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= '0;
    end else if (state_q == ST_ACK) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_q == IW'(i) && cnt_q[i*CW +: CW] != {CW{1'b1}}) begin
          cnt_q[i*CW +: CW] <= cnt_q[i*CW +: CW] + CW'(1);
        end
      end
    end
  end

  assign gnt_cnt = cnt_q;
`endif

endmodule
